// File: rtl/tea_pkg.sv
// Shared types and constants for the byte-stream front-end of the TEA-style cipher core.
package tea_pkg;
  localparam int TEA_WORD_W     = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = TEA_WORD_W / BYTE_W;

  localparam logic [BYTE_W-1:0] PAD_BYTE_DEFAULT = 8'h00;

  typedef enum logic [2:0] {
    FILL,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    DRAIN
  } state_t;

  function automatic logic [BYTE_W-1:0] word_byte(input logic [TEA_WORD_W-1:0] w,
                                                  input logic [1:0]            n);
    logic [TEA_WORD_W-1:0] sh;
    sh = w >> {n, 3'b000};
    return sh[BYTE_W-1:0];
  endfunction
endpackage

// File: rtl/tea_byte_pack.sv
// Packs bytes little-endian into a 32-bit word; a final partial word is padded.
// o_word/o_last/o_done are combinational and valid in the cycle the word completes.
module tea_byte_pack
  import tea_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [BYTE_W-1:0]     i_data,
  input  logic                  i_last,
  output logic [TEA_WORD_W-1:0] o_word,
  output logic                  o_last,
  output logic                  o_done
);
  logic [1:0]            r_idx;
  logic [TEA_WORD_W-1:0] r_word;
  logic [TEA_WORD_W-1:0] w_word_next;

  // Bytes above the current one keep stale data unless this is the last byte.
  always_comb begin
    w_word_next = r_word;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (2'(b) == r_idx) begin
        w_word_next[b*BYTE_W +: BYTE_W] = i_data;
      end else if (i_last && (2'(b) > r_idx)) begin
        w_word_next[b*BYTE_W +: BYTE_W] = PAD_BYTE;
      end
    end
  end

  assign o_word = w_word_next;
  assign o_last = i_last;
  assign o_done = i_valid & ((r_idx == 2'd3) | i_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= 2'd0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= 2'd0;
    end else if (i_valid) begin
      r_word <= w_word_next;
      r_idx  <= o_done ? 2'd0 : r_idx + 2'd1;
    end
  end
endmodule

// File: rtl/tea_cbc_stream.sv
// Byte-stream front-end: pack, optional CBC chaining, one-word core launch, unpack.
// state   | meaning
// FILL    | accepting input bytes into the packer
// ISSUE   | word ready; pulse core_req once the core reports idle
// WAIT_LO | waiting for the core to go busy, bounded by TIMEOUT
// WAIT_HI | waiting for the core to finish; result valid on ack rise
// DRAIN   | presenting the four result bytes, LSB first
module tea_cbc_stream
  import tea_pkg::*;
#(
  parameter bit                CBC      = 1'b1,
  parameter logic [BYTE_W-1:0] PAD_BYTE = PAD_BYTE_DEFAULT,
  parameter logic [15:0]       TIMEOUT  = 16'd1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TEA_WORD_W-1:0] iv,
  input  logic [BYTE_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [BYTE_W-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  core_req,
  output logic [TEA_WORD_W-1:0] core_wdata,
  input  logic                  core_ack,
  input  logic [TEA_WORD_W-1:0] core_rdata,
  output logic                  err,
  output logic                  err_sticky
);
  state_t                r_state, w_state_next;
  logic [TEA_WORD_W-1:0] r_chain, r_wdata, r_out;
  logic                  r_msg_start, r_last_word, r_err_sticky;
  logic [1:0]            r_nbyte;
  logic [15:0]           r_cnt;

  logic                  w_accept, w_pack_done, w_pack_last;
  logic [TEA_WORD_W-1:0] w_pack_word, w_chain_eff;
  logic                  w_launch, w_timeout, w_capture, w_m_fire;

  assign s_ready     = (r_state == FILL) & ~rst;
  assign w_accept    = s_valid & s_ready;
  assign w_chain_eff = r_msg_start ? iv : r_chain;
  assign w_launch    = (r_state == ISSUE) & core_ack;
  assign w_timeout   = (r_state == WAIT_LO) & core_ack & (r_cnt == 16'd0);
  assign w_capture   = (r_state == WAIT_HI) & core_ack;
  assign w_m_fire    = (r_state == DRAIN) & m_ready;

  tea_byte_pack #(.PAD_BYTE(PAD_BYTE)) u_pack (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_timeout),
    .i_valid (w_accept),
    .i_data  (s_data),
    .i_last  (s_last),
    .o_word  (w_pack_word),
    .o_last  (w_pack_last),
    .o_done  (w_pack_done)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    m_valid      = 1'b0;
    m_last       = 1'b0;
    m_data       = '0;
    core_req     = 1'b0;
    err          = 1'b0;
    case (r_state)
      FILL:    if (w_pack_done) w_state_next = ISSUE;
      ISSUE: begin
        if (core_ack) begin
          core_req     = 1'b1;
          w_state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!core_ack) begin
          w_state_next = WAIT_HI;
        end else if (r_cnt == 16'd0) begin
          err          = 1'b1;
          w_state_next = FILL;
        end
      end
      WAIT_HI: if (core_ack) w_state_next = DRAIN;
      DRAIN: begin
        m_valid = 1'b1;
        m_data  = word_byte(r_out, r_nbyte);
        m_last  = r_last_word & (r_nbyte == 2'd3);
        if (m_ready && (r_nbyte == 2'd3)) w_state_next = FILL;
      end
      default: w_state_next = FILL;
    endcase
    // A reset cycle must never signal the core or downstream.
    if (rst) begin
      m_valid  = 1'b0;
      m_last   = 1'b0;
      m_data   = '0;
      core_req = 1'b0;
      err      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain      <= iv;
      r_msg_start  <= 1'b1;
      r_wdata      <= '0;
      r_last_word  <= 1'b0;
      r_out        <= '0;
      r_nbyte      <= 2'd0;
      r_cnt        <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_pack_done) begin
        r_wdata     <= CBC ? (w_pack_word ^ w_chain_eff) : w_pack_word;
        r_last_word <= w_pack_last;
        r_msg_start <= 1'b0;
      end
      if (w_launch) begin
        r_cnt <= TIMEOUT - 16'd1;
      end else if ((r_state == WAIT_LO) && (r_cnt != 16'd0)) begin
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_timeout) begin
        r_err_sticky <= 1'b1;
        r_chain      <= iv;
        r_msg_start  <= 1'b1;
      end
      if (w_capture) begin
        r_out   <= core_rdata;
        r_nbyte <= 2'd0;
        if (CBC) r_chain <= core_rdata;
      end
      if (w_m_fire) begin
        r_nbyte <= r_nbyte + 2'd1;
        if ((r_nbyte == 2'd3) && r_last_word) begin
          r_chain     <= iv;
          r_msg_start <= 1'b1;
        end
      end
    end
  end

  assign core_wdata = r_wdata;
  assign err_sticky = r_err_sticky;
endmodule

// File: tb/tb_tea_cbc_stream.sv
// Directed bench: an ECB instance (TIMEOUT=8) and a CBC instance, each behind a stub core
// whose ack drops one cycle after req and whose result is the inverted request word.
module tb_tea_cbc_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stub_rst = 1'b1, dead = 1'b0, sel = 1'b0;
  int          lo_cycles = 1;
  logic [31:0] iv = 32'h0000_00FF;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  int          nvec = 0, nbad = 0;

  logic        e_s_valid, e_s_ready, e_m_valid, e_m_last, e_req, e_err, e_sticky, e_ack;
  logic [7:0]  e_m_data;
  logic [31:0] e_wdata, e_rdata;
  int          e_cnt;
  logic        c_s_valid, c_s_ready, c_m_valid, c_m_last, c_req, c_err, c_sticky, c_ack;
  logic [7:0]  c_m_data;
  logic [31:0] c_wdata, c_rdata;
  int          c_cnt;

  assign e_s_valid = s_valid & ~sel;
  assign c_s_valid = s_valid & sel;

  logic        s_ready_m, m_valid_m, m_last_m, req_m, err_m, sticky_m;
  logic [7:0]  m_data_m;
  logic [31:0] wdata_m;
  assign s_ready_m = sel ? c_s_ready : e_s_ready;
  assign m_valid_m = sel ? c_m_valid : e_m_valid;
  assign m_last_m  = sel ? c_m_last  : e_m_last;
  assign req_m     = sel ? c_req     : e_req;
  assign err_m     = sel ? c_err     : e_err;
  assign sticky_m  = sel ? c_sticky  : e_sticky;
  assign m_data_m  = sel ? c_m_data  : e_m_data;
  assign wdata_m   = sel ? c_wdata   : e_wdata;

  tea_cbc_stream #(.CBC(1'b0), .PAD_BYTE(8'h00), .TIMEOUT(16'd8)) u_ecb (
    .clk(clk), .rst(rst), .iv(iv),
    .s_data(s_data), .s_valid(e_s_valid), .s_ready(e_s_ready), .s_last(s_last),
    .m_data(e_m_data), .m_valid(e_m_valid), .m_ready(m_ready), .m_last(e_m_last),
    .core_req(e_req), .core_wdata(e_wdata), .core_ack(e_ack), .core_rdata(e_rdata),
    .err(e_err), .err_sticky(e_sticky)
  );

  tea_cbc_stream #(.CBC(1'b1), .PAD_BYTE(8'h00), .TIMEOUT(16'd1024)) u_cbc (
    .clk(clk), .rst(rst), .iv(iv),
    .s_data(s_data), .s_valid(c_s_valid), .s_ready(c_s_ready), .s_last(s_last),
    .m_data(c_m_data), .m_valid(c_m_valid), .m_ready(m_ready), .m_last(c_m_last),
    .core_req(c_req), .core_wdata(c_wdata), .core_ack(c_ack), .core_rdata(c_rdata),
    .err(c_err), .err_sticky(c_sticky)
  );

  always @(posedge clk) begin
    if (stub_rst) begin
      e_ack <= 1'b1; e_cnt <= 0; e_rdata <= '0;
    end else if (dead) begin
      e_ack <= 1'b1;
    end else if (e_req) begin
      e_ack <= 1'b0; e_cnt <= lo_cycles;
    end else if (!e_ack) begin
      if (e_cnt <= 1) begin e_ack <= 1'b1; e_rdata <= ~e_wdata; end
      else e_cnt <= e_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (stub_rst) begin
      c_ack <= 1'b1; c_cnt <= 0; c_rdata <= '0;
    end else if (dead) begin
      c_ack <= 1'b1;
    end else if (c_req) begin
      c_ack <= 1'b0; c_cnt <= lo_cycles;
    end else if (!c_ack) begin
      if (c_cnt <= 1) begin c_ack <= 1'b1; c_rdata <= ~c_wdata; end
      else c_cnt <= c_cnt - 1;
    end
  end

  int req_cnt = 0, err_cnt = 0, mv_cnt = 0, hs_cnt = 0;
  always @(posedge clk) begin
    if (req_m) req_cnt <= req_cnt + 1;
    if (err_m) err_cnt <= err_cnt + 1;
    if (m_valid_m) mv_cnt <= mv_cnt + 1;
    if (m_valid_m && m_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_data = d; s_valid = 1'b1; s_last = l;
    while (!s_ready_m && n < 50) begin @(negedge clk); n++; end
    if (!s_ready_m) begin
      nvec++; nbad++;
      $display("FAIL send_byte %h: s_ready stayed 0, expected 1", d);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic check_req(input logic [31:0] exp, input string name);
    int n = 0;
    while (!req_m && n < 20) begin @(negedge clk); n++; end
    nvec++;
    if (req_m !== 1'b1 || wdata_m !== exp) begin
      nbad++;
      $display("FAIL %s: core_req=%0b core_wdata=%h, expected core_req=1 core_wdata=%h",
               name, req_m, wdata_m, exp);
    end
  endtask

  task automatic recv_byte(input logic [7:0] exp_d, input logic exp_l, input string name);
    int n = 0;
    while (!m_valid_m && n < 20) begin @(negedge clk); n++; end
    nvec++;
    if (m_valid_m !== 1'b1 || m_data_m !== exp_d || m_last_m !== exp_l) begin
      nbad++;
      $display("FAIL %s: m_valid=%0b m_data=%h m_last=%0b, expected 1 %h %0b",
               name, m_valid_m, m_data_m, m_last_m, exp_d, exp_l);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; stub_rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1); #1;
      nvec++;
      if ({s_ready_m, m_valid_m, m_last_m, req_m, err_m, sticky_m} !== 6'b0) begin
        nbad++;
        $display("FAIL reset_ctl[%0d]: {s_ready,m_valid,m_last,req,err,sticky}=%b, expected 000000",
                 k, {s_ready_m, m_valid_m, m_last_m, req_m, err_m, sticky_m});
      end
      nvec++;
      if (wdata_m !== 32'h0 || m_data_m !== 8'h00) begin
        nbad++;
        $display("FAIL reset_data[%0d]: core_wdata=%h m_data=%h, expected 0 0", k, wdata_m, m_data_m);
      end
    end
    rst = 1'b0; stub_rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1); #1;
      nvec++;
      if (s_ready_m !== 1'b1) begin
        nbad++;
        $display("FAIL reset_release[%0d]: s_ready=%0b, expected 1", k, s_ready_m);
      end
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ecb();
    int e0;
    sel = 1'b0; e0 = err_cnt;
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
    check_req(32'h4433_2211, "ecb_wdata");
    recv_byte(8'hEE, 1'b0, "ecb_b0"); recv_byte(8'hDD, 1'b0, "ecb_b1");
    recv_byte(8'hCC, 1'b0, "ecb_b2"); recv_byte(8'hBB, 1'b1, "ecb_b3");
    nvec++;
    if (err_cnt != e0 || sticky_m !== 1'b0) begin
      nbad++;
      $display("FAIL ecb_err: err pulses=%0d err_sticky=%0b, expected 0 0", err_cnt - e0, sticky_m);
    end
  endtask

  task automatic test_partial();
    sel = 1'b0;
    send_byte(8'hAA, 1'b1);
    check_req(32'h0000_00AA, "pad3_wdata");
    recv_byte(8'h55, 1'b0, "pad3_b0"); recv_byte(8'hFF, 1'b0, "pad3_b1");
    recv_byte(8'hFF, 1'b0, "pad3_b2"); recv_byte(8'hFF, 1'b1, "pad3_b3");
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b1);
    check_req(32'h0000_3412, "pad2_wdata");
    recv_byte(8'hED, 1'b0, "pad2_b0"); recv_byte(8'hCB, 1'b0, "pad2_b1");
    recv_byte(8'hFF, 1'b0, "pad2_b2"); recv_byte(8'hFF, 1'b1, "pad2_b3");
  endtask

  task automatic test_backpressure();
    int h0, n;
    sel = 1'b0;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b1);
    check_req(32'h0403_0201, "bp_wdata");
    h0 = hs_cnt;
    recv_byte(8'hFE, 1'b0, "bp_b0");
    n = 0;
    while (!m_valid_m && n < 20) begin @(negedge clk); n++; end
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (m_valid_m !== 1'b1 || m_data_m !== 8'hFD || s_ready_m !== 1'b0) begin
        nbad++;
        $display("FAIL bp_hold[%0d]: m_valid=%0b m_data=%h s_ready=%0b, expected 1 fd 0",
                 i, m_valid_m, m_data_m, s_ready_m);
      end
      @(negedge clk);
    end
    m_ready = 1'b1;
    recv_byte(8'hFD, 1'b0, "bp_b1"); recv_byte(8'hFC, 1'b0, "bp_b2"); recv_byte(8'hFB, 1'b1, "bp_b3");
    nvec++;
    if (hs_cnt - h0 != 4) begin
      nbad++;
      $display("FAIL bp_count: handshakes=%0d, expected 4", hs_cnt - h0);
    end
  endtask

  task automatic test_timeout();
    int r0, m0, k;
    sel = 1'b0; dead = 1'b1; r0 = req_cnt; m0 = mv_cnt;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b1);
    check_req(32'h0403_0201, "to_wdata");
    k = 0;
    do begin @(negedge clk); k++; end while (!err_m && k < 20);
    nvec++;
    if (err_m !== 1'b1 || k != 8) begin
      nbad++;
      $display("FAIL to_err_time: err=%0b after %0d cycles, expected err=1 after 8", err_m, k);
    end
    @(negedge clk);
    nvec++;
    if (err_m !== 1'b0 || sticky_m !== 1'b1) begin
      nbad++;
      $display("FAIL to_sticky: err=%0b err_sticky=%0b, expected 0 1", err_m, sticky_m);
    end
    nvec++;
    if (s_ready_m !== 1'b1) begin
      nbad++;
      $display("FAIL to_refill: s_ready=%0b, expected 1", s_ready_m);
    end
    repeat (5) @(negedge clk);
    nvec++;
    if (req_cnt - r0 != 1 || mv_cnt != m0) begin
      nbad++;
      $display("FAIL to_counts: req pulses=%0d m_valid cycles=%0d, expected 1 0", req_cnt - r0, mv_cnt - m0);
    end
    dead = 1'b0;
  endtask

  task automatic test_cbc();
    sel = 1'b1;
    repeat (4) send_byte(8'h00, 1'b0);
    check_req(32'h0000_00FF, "cbc_w0");
    recv_byte(8'h00, 1'b0, "cbc_b0"); recv_byte(8'hFF, 1'b0, "cbc_b1");
    recv_byte(8'hFF, 1'b0, "cbc_b2"); recv_byte(8'hFF, 1'b0, "cbc_b3");
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b1);
    check_req(32'hFFFF_FF01, "cbc_w1");
    recv_byte(8'hFE, 1'b0, "cbc_b4"); recv_byte(8'h00, 1'b0, "cbc_b5");
    recv_byte(8'h00, 1'b0, "cbc_b6"); recv_byte(8'h00, 1'b1, "cbc_b7");
    repeat (3) send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    check_req(32'h0000_00FF, "cbc_reseed");
    recv_byte(8'h00, 1'b0, "cbc_rs_b0"); recv_byte(8'hFF, 1'b0, "cbc_rs_b1");
    recv_byte(8'hFF, 1'b0, "cbc_rs_b2"); recv_byte(8'hFF, 1'b1, "cbc_rs_b3");
  endtask

  task automatic test_rst_midflight();
    int m0;
    sel = 1'b1;
    repeat (4) send_byte(8'h00, 1'b0);
    check_req(32'h0000_00FF, "mid_w0");
    recv_byte(8'h00, 1'b0, "mid_b0"); recv_byte(8'hFF, 1'b0, "mid_b1");
    recv_byte(8'hFF, 1'b0, "mid_b2"); recv_byte(8'hFF, 1'b0, "mid_b3");
    lo_cycles = 6;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b1);
    check_req(32'hFBFC_FD01, "mid_w1");
    repeat (3) @(negedge clk);
    m0 = mv_cnt;
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({req_m, s_ready_m, m_valid_m} !== 3'b000) begin
      nbad++;
      $display("FAIL mid_in_rst: {core_req,s_ready,m_valid}=%b, expected 000", {req_m, s_ready_m, m_valid_m});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    nvec++;
    if (mv_cnt != m0 || {s_ready_m, req_m} !== 2'b10 || wdata_m !== 32'h0) begin
      nbad++;
      $display("FAIL mid_after: m_valid cycles=%0d s_ready=%0b core_req=%0b core_wdata=%h, expected 0 1 0 0",
               mv_cnt - m0, s_ready_m, req_m, wdata_m);
    end
    lo_cycles = 1;
    repeat (3) send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    check_req(32'h0000_00FF, "mid_chain_iv");
    recv_byte(8'h00, 1'b0, "mid_n_b0"); recv_byte(8'hFF, 1'b0, "mid_n_b1");
    recv_byte(8'hFF, 1'b0, "mid_n_b2"); recv_byte(8'hFF, 1'b1, "mid_n_b3");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ecb();
    test_partial();
    test_backpressure();
    test_timeout();
    test_cbc();
    test_rst_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
